// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared prescaler and period counter, per-channel double-buffered mode/compares.
// Latency: pwm_out is registered one clk behind count_out; shadow->active load on a wrap step (or while idle), upd_ack 1 clk later.
// Backpressure: none; upd_req is a pulse that sets a pending flag, repeated requests merge into one load.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   en                  counter/PWM enable; when low, counter and prescaler sit at 0
//   period, prescale    shadow period (count 0..period) and live prescaler (step every prescale+1 clk)
//   mode_in             shadow modes, 2 bits per channel
//   cmp1_in, cmp2_in    shadow compares, CNT_W bits per channel
//   upd_req / upd_ack   request a shadow->active load / one-clk pulse after the load
//   period_tick         one-clk pulse coincident with count_out returning to 0 on a wrap
//   count_out, pwm_out  current counter value, registered PWM outputs
module pwm_multi_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_W-1:0]        period,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic [2*NUM_CH-1:0]     mode_in,
  input  logic [CNT_W*NUM_CH-1:0] cmp1_in,
  input  logic [CNT_W*NUM_CH-1:0] cmp2_in,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic                    period_tick,
  output logic [CNT_W-1:0]        count_out,
  output logic [NUM_CH-1:0]       pwm_out
);

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_RANGE = 2'b10;

  logic [PRESC_W-1:0]      psc_q, psc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    pending_q, pending_d;
  logic                    upd_ack_q, upd_ack_d;
  logic                    tick_q, tick_d;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic [CNT_W-1:0]        period_act_q, period_act_d;
  logic [2*NUM_CH-1:0]     mode_act_q, mode_act_d;
  logic [CNT_W*NUM_CH-1:0] cmp1_act_q, cmp1_act_d;
  logic [CNT_W*NUM_CH-1:0] cmp2_act_q, cmp2_act_d;

  logic step;
  logic wrap;
  logic load;

  // Per-channel waveform decode. Equal compares force the output low in
  // every mode so a channel can be parked by writing a==b.
  function automatic logic ch_decode(input logic [1:0]       m,
                                     input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] a,
                                     input logic [CNT_W-1:0] b);
    logic r;
    r = 1'b0;
    if (a != b) begin
      case (m)
        MODE_LEFT:  r = (a != '0) && (c <= a);
        MODE_RIGHT: r = (c >= a);
        MODE_RANGE: r = (a < b) && (c >= a) && (c < b);
        default:    r = (a < b) && ((c < a) || (c >= b));
      endcase
    end
    return r;
  endfunction

  always_comb begin
    psc_d        = psc_q;
    count_d      = count_q;
    period_act_d = period_act_q;
    mode_act_d   = mode_act_q;
    cmp1_act_d   = cmp1_act_q;
    cmp2_act_d   = cmp2_act_q;
    pwm_d        = '0;
    step         = 1'b0;
    wrap         = 1'b0;

    if (!en) begin
      psc_d   = '0;
      count_d = '0;
    end else begin
      // >= rather than == so lowering prescale while running cannot make
      // the prescaler run the long way round through its full range.
      if (psc_q >= prescale) begin
        psc_d = '0;
        step  = 1'b1;
      end else begin
        psc_d = psc_q + 1'b1;
      end

      if (step) begin
        // >= also covers a period_act of 0: the count stays at 0 and every
        // step is a wrap.
        if (count_q >= period_act_q) begin
          count_d = '0;
          wrap    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end

    // Shadow values are sampled here, at load time, so late writes after
    // the request still make it into the active set.
    load = pending_q && (wrap || !en);
    if (load) begin
      period_act_d = period;
      mode_act_d   = mode_in;
      cmp1_act_d   = cmp1_in;
      cmp2_act_d   = cmp2_in;
    end

    // A request landing on the load clk re-arms for the next boundary.
    pending_d = load ? upd_req : (pending_q || upd_req);
    upd_ack_d = load;
    tick_d    = wrap;

    // Decode uses the pre-load active set; a new set first shows on the
    // output for count 0 of the following period.
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = en && ch_decode(mode_act_q[2*i +: 2], count_q,
                                 cmp1_act_q[CNT_W*i +: CNT_W],
                                 cmp2_act_q[CNT_W*i +: CNT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q        <= '0;
      count_q      <= '0;
      pending_q    <= 1'b0;
      upd_ack_q    <= 1'b0;
      tick_q       <= 1'b0;
      pwm_q        <= '0;
      period_act_q <= '0;
      mode_act_q   <= '0;
      cmp1_act_q   <= '0;
      cmp2_act_q   <= '0;
    end else begin
      psc_q        <= psc_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      upd_ack_q    <= upd_ack_d;
      tick_q       <= tick_d;
      pwm_q        <= pwm_d;
      period_act_q <= period_act_d;
      mode_act_q   <= mode_act_d;
      cmp1_act_q   <= cmp1_act_d;
      cmp2_act_q   <= cmp2_act_d;
    end
  end

  assign upd_ack     = upd_ack_q;
  assign period_tick = tick_q;
  assign count_out   = count_q;
  assign pwm_out     = pwm_q;

endmodule
